// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multicycle MIPS control FSM
// Contents: opcode/funct constants, aluControl and aluSrcB encodings,
// the FSM state enumeration and the control-strobe bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ_EX   = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_TRAP     = 4'd12,
    S_INTR     = 4'd13
  } state_t;

  typedef struct packed {
    logic [1:0] aluControl;
    logic [1:0] aluSrcB;
    logic       aluSrcA;
    logic       PCSource;
    logic       PCWrite;
    logic       isBranch;
    logic       lorD;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       RegDst;
    logic       RegWrite;
    logic       isInterrupted;
    logic       irqAck;
    logic       illegalOp;
  } ctrl_t;

  function automatic logic isDefinedFunct(input logic [5:0] f);
    return (f == F_ADD) || (f == F_SUB) || (f == F_AND) || (f == F_OR) || (f == F_SLT);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// rtl/multicycle_ctrl_outdec.sv - Moore output decode of the control FSM state
// Ports:
//   state - current FSM state
//   ctrl  - every datapath control strobe for that state
// Optional: MULTICYCLE_CONTROL_IRQ_EN adds decode of the INTR state.
module multicycle_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.IRWrite = 1'b1;
        ctrl.aluSrcB = SRCB_FOUR;
        ctrl.PCWrite = 1'b1;
      end
      // Branch target is computed speculatively while the opcode decodes.
      S_DECODE: ctrl.aluSrcB = SRCB_IMMSH2;
      S_MEMADR, S_ADDI_EX: begin
        ctrl.aluSrcA = 1'b1;
        ctrl.aluSrcB = SRCB_IMM;
      end
      S_MEMRD: ctrl.lorD = 1'b1;
      S_MEMWB: begin
        ctrl.MemtoReg = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.lorD     = 1'b1;
        ctrl.MemWrite = 1'b1;
      end
      S_RTYPE_EX: begin
        ctrl.aluSrcA    = 1'b1;
        ctrl.aluSrcB    = SRCB_REGB;
        ctrl.aluControl = ALU_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.RegDst   = 1'b1;
        ctrl.RegWrite = 1'b1;
      end
      S_BEQ_EX: begin
        ctrl.aluSrcA    = 1'b1;
        ctrl.aluControl = ALU_SUB;
        ctrl.PCSource   = 1'b1;
        ctrl.isBranch   = 1'b1;
      end
      S_ADDI_WB: ctrl.RegWrite = 1'b1;
      S_TRAP:    ctrl.illegalOp = 1'b1;
`ifdef MULTICYCLE_CONTROL_IRQ_EN
      S_INTR: begin
        ctrl.isInterrupted = 1'b1;
        ctrl.PCWrite       = 1'b1;
        ctrl.irqAck        = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM of the multicycle MIPS datapath
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   op, funct          - instruction fields from the datapath IR
//   irq                - level interrupt request
//   aluControl..RegWrite, isInterrupted, irq_ack - datapath strobes
//   illegal_op         - high while halted on an undefined instruction
// Optional: MULTICYCLE_CONTROL_IRQ_EN enables single-level interrupt entry.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W     = 4,
  parameter bit CHECK_FUNCT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       irq,
  output logic [1:0] aluControl,
  output logic [1:0] aluSrcB,
  output logic       aluSrcA,
  output logic       PCSource,
  output logic       PCWrite,
  output logic       isBranch,
  output logic       lorD,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       isInterrupted,
  output logic       irq_ack,
  output logic       illegal_op
);

  logic [STATE_W-1:0] stateQ;
  state_t             state;
  state_t             stateNext;
  state_t             doneNext;
  ctrl_t              ctrl;
  logic               rtypeLegal;
  logic               takeIrq;

  assign state = state_t'(stateQ);

  always_ff @(posedge clk) begin
    if (rst) stateQ <= STATE_W'(S_RESET);
    else     stateQ <= STATE_W'(stateNext);
  end

  assign rtypeLegal = !CHECK_FUNCT || isDefinedFunct(funct);

`ifdef MULTICYCLE_CONTROL_IRQ_EN
  assign takeIrq = irq;
`else
  logic unusedIrq;
  assign unusedIrq = irq;
  assign takeIrq   = 1'b0;
`endif

  // Where every completing instruction goes next.
  assign doneNext = takeIrq ? S_INTR : S_FETCH;

  always_comb begin
    stateNext = S_RESET;
    case (state)
      S_RESET:  stateNext = S_FETCH;
      S_FETCH:  stateNext = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     stateNext = rtypeLegal ? S_RTYPE_EX : S_TRAP;
          OP_LW, OP_SW: stateNext = S_MEMADR;
          OP_BEQ:       stateNext = S_BEQ_EX;
          OP_ADDI:      stateNext = S_ADDI_EX;
          default:      stateNext = S_TRAP;
        endcase
      end
      S_MEMADR:   stateNext = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    stateNext = S_MEMWB;
      S_RTYPE_EX: stateNext = S_RTYPE_WB;
      S_ADDI_EX:  stateNext = S_ADDI_WB;
      S_MEMWB, S_MEMWR, S_RTYPE_WB, S_BEQ_EX, S_ADDI_WB: stateNext = doneNext;
      S_TRAP:     stateNext = S_TRAP;
`ifdef MULTICYCLE_CONTROL_IRQ_EN
      S_INTR:     stateNext = S_FETCH;
`endif
      default:    stateNext = S_RESET;
    endcase
  end

  multicycle_ctrl_outdec uOutdec (
    .state (state),
    .ctrl  (ctrl)
  );

  // Architectural writes are suppressed in the cycle rst is seen, so an
  // abandoned instruction never commits anything on the reset edge.
  assign PCWrite       = ctrl.PCWrite  & ~rst;
  assign MemWrite      = ctrl.MemWrite & ~rst;
  assign IRWrite       = ctrl.IRWrite  & ~rst;
  assign RegWrite      = ctrl.RegWrite & ~rst;
  assign aluControl    = ctrl.aluControl;
  assign aluSrcB       = ctrl.aluSrcB;
  assign aluSrcA       = ctrl.aluSrcA;
  assign PCSource      = ctrl.PCSource;
  assign isBranch      = ctrl.isBranch;
  assign lorD          = ctrl.lorD;
  assign MemtoReg      = ctrl.MemtoReg;
  assign RegDst        = ctrl.RegDst;
  assign isInterrupted = ctrl.isInterrupted;
  assign irq_ack       = ctrl.irqAck;
  assign illegal_op    = ctrl.illegalOp;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS DataPath.
- Consumes op/funct from the datapath instruction register and drives every datapath control strobe, one state per cycle.
- Supports R-type (add/sub/and/or/slt), lw, sw, beq and addi, plus an optional single-level interrupt entry.
- Sits beside DataPath in the CPU top level; all outputs are Moore-decoded from the state register.

Parameters:
- STATE_W, 4, width of the state register; must hold 14 states.
- CHECK_FUNCT, 1, when 1 an undefined R-type funct traps as illegal; when 0 any funct is accepted.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  opcode from datapath IR.
- funct  in  6  function field from datapath IR.
- irq  in  1  level interrupt request (used only with IRQ_EN).
- aluControl  out  2  00 add, 01 sub, 10 decode from funct.
- aluSrcB  out  2  00 regB, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- aluSrcA  out  1  0 PC, 1 regA.
- PCSource  out  1  0 ALU result, 1 ALUOut.
- PCWrite  out  1  unconditional PC load.
- isBranch  out  1  PC load qualified by ALU zero.
- lorD  out  1  memory address select: 0 PC, 1 ALUOut.
- MemWrite  out  1  memory write strobe.
- MemtoReg  out  1  register write data: 0 ALUOut, 1 MDR.
- IRWrite  out  1  IR load.
- RegDst  out  1  destination: 0 rt, 1 rd.
- RegWrite  out  1  register file write.
- isInterrupted  out  1  datapath loads interrupt vector into PC.
- irq_ack  out  1  one-cycle interrupt acknowledge.
- illegal_op  out  1  sticky; core halted on an undefined instruction.

Behaviour:
- Reset: rst sampled high sets state to RESET. In RESET every output is 0. The state moves to FETCH on the first clock edge with rst low.
- rst asserted in any state returns the FSM to RESET on the next edge. An in-flight instruction is abandoned and no partial write completes after that edge.
- Outputs are driven as listed per state. Any signal not listed is 0.
- FETCH: IRWrite=1, aluSrcB=01, PCWrite=1. Next state is DECODE.
- DECODE: aluSrcB=11 (branch target into ALUOut). Next state by op:
  - 000000 goes to RTYPE_EX.
  - 100011 and 101011 go to MEMADR.
  - 000100 goes to BEQ_EX.
  - 001000 goes to ADDI_EX.
  - Any other op goes to TRAP.
  - op 000000 with an undefined funct goes to TRAP when CHECK_FUNCT=1. Defined functs are 100000, 100010, 100100, 100101, 101010.
- MEMADR: aluSrcA=1, aluSrcB=10. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: lorD=1. Next state is MEMWB.
- MEMWB: MemtoReg=1, RegWrite=1, RegDst=0.
- MEMWR: lorD=1, MemWrite=1.
- RTYPE_EX: aluSrcA=1, aluSrcB=00, aluControl=10. Next state is RTYPE_WB.
- RTYPE_WB: RegDst=1, RegWrite=1.
- BEQ_EX: aluSrcA=1, aluControl=01, PCSource=1, isBranch=1.
- ADDI_EX: aluSrcA=1, aluSrcB=10. Next state is ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0.
- Instruction completion states are MEMWB, MEMWR, RTYPE_WB, BEQ_EX and ADDI_WB. Each goes to FETCH, or to INTR (see Optional Feature).
- Cycles from FETCH to the next FETCH:

  | Instruction | Cycles |
  |---|---|
  | beq | 3 |
  | sw, R-type, addi | 4 |
  | lw | 5 |

- TRAP: all strobes are 0 and illegal_op=1. The FSM stays in TRAP until rst.
- RegWrite, MemWrite, PCWrite and IRWrite are never high in the same cycle as rst.
- Unused state encodings decode as all-zero outputs and return to RESET.

Optional Feature:
- Macro MULTICYCLE_CONTROL_IRQ_EN.
- Defined:
  - irq is sampled in each instruction completion state. If it is high, the next state is INTR instead of FETCH.
  - INTR: isInterrupted=1, PCWrite=1, irq_ack=1 for exactly one cycle. Next state is FETCH.
  - irq in any other state has no effect. There is no nesting: the requester must drop irq after irq_ack.
  - irq in TRAP or RESET is ignored.
- Undefined: the INTR state does not exist, irq is ignored, and isInterrupted and irq_ack are tied to 0.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - funct constants: F_ADD, F_SUB, F_AND, F_OR, F_SLT;
  - aluControl and aluSrcB encodings;
  - the state enumeration.
- One sub-module, multicycle_ctrl_outdec: purely combinational, state in, all control strobes out. The top module keeps the state register and next-state logic.

Test Plan:
- rst high 3 cycles, then low → all outputs 0 during reset; FETCH one cycle after release with IRWrite=1, PCWrite=1, aluSrcB=01.
- op=000000, funct=100000 → FETCH, DECODE(aluSrcB=11), RTYPE_EX(aluControl=10, aluSrcA=1), RTYPE_WB(RegDst=1, RegWrite=1), FETCH. Exactly 4 cycles.
- op=100011 then op=101011 → lw takes 5 cycles with MEMWB MemtoReg=1; sw takes 4 cycles with MEMWR lorD=1, MemWrite=1; RegWrite stays 0 throughout sw.
- op=000100 → BEQ_EX with aluControl=01, isBranch=1, PCSource=1, then FETCH. op=111111, then op=000000 with funct=000111 (CHECK_FUNCT=1) → TRAP, illegal_op=1 held 10 cycles; rst clears it.
- rst pulsed during MEMRD of lw → RESET next edge, no RegWrite pulse, clean restart at FETCH.
- IRQ_EN: irq=1 raised during RTYPE_EX → RTYPE_WB completes, then INTR for 1 cycle (isInterrupted=1, PCWrite=1, irq_ack=1), then FETCH. Without IRQ_EN: isInterrupted never asserts.
